// File: rtl/maths_pkg.sv
// Shared definitions for the maths add/sub family: mode encodings,
// default operand width and the pipeline stage record.
package maths_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    MODE_ADD_WRAP = 2'd0,
    MODE_ADD_USAT = 2'd1,
    MODE_ADD_SSAT = 2'd2,
    MODE_SUB_WRAP = 2'd3
  } mode_e;

  typedef struct packed {
    logic                     valid;
    logic [DEFAULT_WIDTH-1:0] z;
    logic                     ovf;
  } stage_t;

endpackage

// File: rtl/maths_addsub_core.sv
// Combinational add/sub datapath: wrap, unsigned-saturate, signed-saturate
// and wrapping subtract, each with its overflow/clamp/borrow flag.
module maths_addsub_core
  import maths_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] z_o,
  output logic             ovf_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           sovf;

  always_comb begin
    sum   = {1'b0, x_i} + {1'b0, y_i};
    diff  = {1'b0, x_i} - {1'b0, y_i};
    // Signed overflow: operands agree in sign but the result does not.
    sovf  = (x_i[WIDTH-1] == y_i[WIDTH-1]) && (sum[WIDTH-1] != x_i[WIDTH-1]);
    z_o   = '0;
    ovf_o = 1'b0;
    case (mode_e'(mode_i))
      MODE_ADD_WRAP: begin
        z_o   = sum[WIDTH-1:0];
        ovf_o = sum[WIDTH];
      end
      MODE_ADD_USAT: begin
        z_o   = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        ovf_o = sum[WIDTH];
      end
      MODE_ADD_SSAT: begin
        if (sovf)
          z_o = x_i[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
          z_o = sum[WIDTH-1:0];
        ovf_o = sovf;
      end
      MODE_SUB_WRAP: begin
        z_o   = diff[WIDTH-1:0];
        ovf_o = diff[WIDTH];
      end
      default: begin
        z_o   = '0;
        ovf_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/maths_pipe_addsub.sv
// Pipelined add/sub with valid/ready handshake, STAGES-cycle latency,
// full backpressure and a wrapping completed-result counter.
module maths_pipe_addsub
  import maths_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned STAGES = 3,
  parameter int unsigned CNTW   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             ovf,
  output logic [CNTW-1:0]  count
);

  // Same layout as maths_pkg::stage_t, but sized by this instance's WIDTH.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] z;
    logic             ovf;
  } pstage_t;

  pstage_t          stage_q [STAGES];
  pstage_t          stage_d [STAGES];
  logic [CNTW-1:0]  count_q;
  logic [CNTW-1:0]  count_d;
  logic [WIDTH-1:0] core_z;
  logic             core_ovf;
  logic             advance;

  maths_addsub_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .x_i   (x),
    .y_i   (y),
    .mode_i(mode),
    .z_o   (core_z),
    .ovf_o (core_ovf)
  );

  assign advance   = !stage_q[STAGES-1].valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = stage_q[STAGES-1].valid;
  assign z         = out_valid ? stage_q[STAGES-1].z : '0;
  assign ovf       = out_valid && stage_q[STAGES-1].ovf;
  assign count     = count_q;

  always_comb begin
    stage_d = stage_q;
    count_d = count_q;
    if (advance) begin
      stage_d[0] = '{valid: in_valid, z: core_z, ovf: core_ovf};
      for (int unsigned i = 1; i < STAGES; i++)
        stage_d[i] = stage_q[i-1];
    end
    if (out_valid && out_ready)
      count_d = count_q + CNTW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < STAGES; i++)
        stage_q[i] <= '0;
      count_q <= '0;
    end else begin
      stage_q <= stage_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_maths_pipe_addsub.sv
// Directed bench for maths_pipe_addsub: latency, saturation, backpressure,
// streaming, asynchronous reset and counter wrap.
module tb_maths_pipe_addsub;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic [1:0]  mode = '0;
  logic        in_ready, out_valid, ovf;
  logic [15:0] z;
  logic [15:0] count;

  int unsigned passed = 0;
  int unsigned fails  = 0;
  int unsigned total  = 0;
  logic [16:0] exp_q[$];
  logic [16:0] pend = '0;
  logic [15:0] exp_count = '0;
  bit          sb_en = 1'b1;

  maths_pipe_addsub #(
    .WIDTH (16),
    .STAGES(3),
    .CNTW  (16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y        (y),
    .mode     (mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .z        (z),
    .ovf      (ovf),
    .count    (count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent reference: integer arithmetic with explicit range clamps.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] m);
    int          s;
    logic [15:0] zz;
    logic        oo;
    zz = '0;
    oo = 1'b0;
    case (m)
      2'd0: begin
        s  = int'(a) + int'(b);
        zz = s[15:0];
        oo = (s > 65535);
      end
      2'd1: begin
        s  = int'(a) + int'(b);
        oo = (s > 65535);
        zz = oo ? 16'hFFFF : s[15:0];
      end
      2'd2: begin
        s = int'($signed(a)) + int'($signed(b));
        if (s > 32767) begin
          zz = 16'h7FFF; oo = 1'b1;
        end else if (s < -32768) begin
          zz = 16'h8000; oo = 1'b1;
        end else begin
          zz = s[15:0];
        end
      end
      default: begin
        oo = (a < b);
        zz = a - b;
      end
    endcase
    return {oo, zz};
  endfunction

  task automatic drive(input logic [15:0] xx, input logic [15:0] yy, input logic [1:0] mm,
                       input logic [15:0] ez, input logic eo);
    in_valid = 1'b1;
    x        = xx;
    y        = yy;
    mode     = mm;
    pend     = {eo, ez};
  endtask

  // One clock: score transfers as they happen on the coming edge.
  task automatic cycle();
    logic        acc_in, acc_out;
    logic [16:0] e;
    #1;
    acc_in  = in_valid && in_ready;
    acc_out = out_valid && out_ready;
    if (acc_out) begin
      exp_count++;
      if (sb_en) begin
        check("result_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("z", 32'(z), 32'(e[15:0]));
          check("ovf", 32'(ovf), 32'(e[16]));
        end
      end
    end
    if (acc_in && sb_en)
      exp_q.push_back(pend);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    in_valid = 1'b0;
    repeat (n) cycle();
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_z", 32'(z), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_count", 32'(count), 0);
    @(posedge clock);
    #1 reset = 1'b1;
    #1 check("post_rst_in_ready", 32'(in_ready), 1);

    // 1: stream three pairs, check latency
    out_ready = 1'b1;
    drive(16'h1234, 16'h0001, 2'd0, 16'h1235, 1'b0);
    cycle();
    check("lat_ov_1", 32'(out_valid), 0);
    drive(16'hFFFF, 16'h0002, 2'd0, 16'h0001, 1'b1);
    cycle();
    check("lat_ov_2", 32'(out_valid), 0);
    drive(16'h0005, 16'h0007, 2'd3, 16'hFFFE, 1'b1);
    cycle();
    check("lat_ov_3", 32'(out_valid), 1);
    check("lat_z_3", 32'(z), 32'h1235);
    idle(3);
    check("t1_count", 32'(count), 3);
    check("t1_drained", 32'(exp_q.size()), 0);

    // 2: saturation corners
    drive(16'hF000, 16'h2000, 2'd1, 16'hFFFF, 1'b1); cycle();
    drive(16'h7000, 16'h2000, 2'd2, 16'h7FFF, 1'b1); cycle();
    drive(16'h8000, 16'hFFFF, 2'd2, 16'h8000, 1'b1); cycle();
    drive(16'h0003, 16'hFFFE, 2'd2, 16'h0001, 1'b0); cycle();
    idle(4);
    check("t2_drained", 32'(exp_q.size()), 0);
    check("t2_count", 32'(count), 7);

    // 3: backpressure
    out_ready = 1'b0;
    drive(16'h0001, 16'h0002, 2'd0, 16'h0003, 1'b0); cycle();
    drive(16'h8000, 16'h8000, 2'd1, 16'hFFFF, 1'b1); cycle();
    drive(16'h0010, 16'h0001, 2'd3, 16'h000F, 1'b0); cycle();
    drive(16'hAAAA, 16'h5555, 2'd0, 16'hFFFF, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_z_hold", 32'(z), 32'h0003);
      check("bp_count", 32'(count), 7);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("drain_ov", 32'(out_valid), 1);
      cycle();
    end
    check("drain_done_ov", 32'(out_valid), 0);
    check("t3_count", 32'(count), 10);
    check("t3_drained", 32'(exp_q.size()), 0);

    // 4: 100 random pairs at full rate
    for (int i = 0; i < 100; i++) begin
      x        = 16'($urandom);
      y        = 16'($urandom);
      mode     = 2'($urandom_range(0, 3));
      pend     = model(x, y, mode);
      in_valid = 1'b1;
      cycle();
      check("stream_in_ready", 32'(in_ready), 1);
    end
    idle(3);
    check("t4_drained", 32'(exp_q.size()), 0);
    check("t4_count", 32'(count), 32'(exp_count));
    check("t4_count_abs", 32'(count), 110);

    // 5: asynchronous reset with results in flight
    drive(16'h0100, 16'h0200, 2'd0, 16'h0300, 1'b0); cycle();
    drive(16'h0400, 16'h0500, 2'd0, 16'h0900, 1'b0); cycle();
    in_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_count", 32'(count), 0);
    exp_q.delete();
    exp_count = '0;
    @(posedge clock);
    #1 reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("no_stale", 32'(out_valid), 0);
    end
    check("post_rst_count", 32'(count), 0);

    // 6: counter wrap
    sb_en = 1'b0;
    in_valid = 1'b1;
    x = 16'h0001; y = 16'h0001; mode = 2'd0;
    for (int i = 0; i < 65535; i++) cycle();
    idle(3);
    check("count_ffff", 32'(count), 32'hFFFF);
    in_valid = 1'b1;
    cycle();
    idle(3);
    check("count_wrap", 32'(count), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/maths_pipe_addsub.md
Name: maths_pipe_addsub

Overview:
Parametrised, pipelined successor to the combinational maths1 adders. Accepts operand pairs over a valid/ready handshake, applies one of four add/sub modes, and delivers the result with an overflow flag after STAGES cycles. Throughput is one result per cycle, with full backpressure. It is built in the same three-flavour style and compared lane-for-lane in the co-simulation bench.

Parameters:
WIDTH, 16, operand and result width in bits (>=2).
STAGES, 3, pipeline depth and accept-to-output latency in cycles (>=1).
CNTW, 16, width of the completed-result counter.

Ports:
clock      in   1      system clock, rising edge.
reset      in   1      asynchronous, active-low reset.
in_valid   in   1      operand pair presented.
in_ready   out  1      block can accept this cycle.
x          in   WIDTH  operand A.
y          in   WIDTH  operand B.
mode       in   2      operation, sampled with the operands.
out_valid  out  1      result presented.
out_ready  in   1      consumer accepts the result.
z          out  WIDTH  result.
ovf        out  1      overflow/saturation/borrow flag for z.
count      out  CNTW   number of results consumed since reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - All stage valid bits clear; out_valid=0, z=0, ovf=0, count=0.
  - in_ready is 1 one cycle after release. Since in_ready is combinational from stage state, it is already 1 during reset.
- Handshake:
  - Input transfer occurs on in_valid & in_ready.
  - Output transfer occurs on out_valid & out_ready.
  - Data and mode are sampled only on an input transfer.
- Pipeline control:
  - advance = !v[STAGES-1] | out_ready.
  - in_ready = advance, purely combinational from state and out_ready.
  - When advance=1, every stage shifts by one. Stage 0 loads {in_valid, result, ovf} computed from x, y and mode.
  - When advance=0, all stages hold. No bubble collapsing.
- Latency and throughput:
  - With out_ready held high, a pair accepted at edge N appears on out_valid/z/ovf after edge N+STAGES-1.
  - That is, it is visible STAGES cycles after the cycle in which it was presented.
  - Sustained rate is 1 per cycle.
- Output hold: while out_valid=1 and out_ready=0, z/ovf/out_valid are stable.
- Invalid stages: payload of a stage with v=0 is don't-care internally, but z and ovf are forced to 0 when out_valid=0.
- Modes (computed at WIDTH+1 bits):
  - 0 ADD_WRAP: z = (x+y) mod 2^WIDTH; ovf = unsigned carry out.
  - 1 ADD_USAT: z = min(x+y, 2^WIDTH-1); ovf = 1 when clamped.
  - 2 ADD_SSAT: two's-complement add, clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; ovf = 1 when clamped.
  - 3 SUB_WRAP: z = (x-y) mod 2^WIDTH; ovf = borrow (x<y unsigned).
- count:
  - Increments on each output transfer, wrapping from 2^CNTW-1 to 0.
  - An input accept and output transfer in the same cycle is normal operation; it has no special effect on count.
- Simultaneous in/out: when the pipe is full and out_ready=1, the final stage empties and a new pair enters in the same cycle.
- Reset mid-operation: all in-flight results are discarded with no output. count returns to 0.

Decomposition:
- Shared package maths_pkg:
  - Mode constants MODE_ADD_WRAP=0, MODE_ADD_USAT=1, MODE_ADD_SSAT=2, MODE_SUB_WRAP=3.
  - Default WIDTH.
  - Stage record {valid, z, ovf}.
- Sub-module maths_addsub_core: purely combinational (x, y, mode) -> (z, ovf), parametrised on WIDTH. It is reused standalone in the flavour-comparison bench.

Test Plan (WIDTH=16, STAGES=3, CNTW=16):
1. Reset then stream, out_ready=1. Send (mode 0) x=0x1234,y=0x0001; x=0xFFFF,y=0x0002; (mode 3) x=0x0005,y=0x0007 on consecutive cycles -> out_valid from the 3rd cycle after the first accept. Results z=0x1235 ovf=0; z=0x0001 ovf=1; z=0xFFFE ovf=1; count=3.
2. Saturation:
   - Mode 1, x=0xF000,y=0x2000 -> z=0xFFFF ovf=1.
   - Mode 2, x=0x7000,y=0x2000 -> z=0x7FFF ovf=1.
   - Mode 2, x=0x8000,y=0xFFFF -> z=0x8000 ovf=1.
   - Mode 2, x=0x0003,y=0xFFFE -> z=0x0001 ovf=0.
3. Backpressure:
   - Fill the pipe with 3 pairs, out_ready=0 -> in_ready=0 and z held stable for 10 cycles, count unchanged.
   - Raise out_ready -> results drain in order, one per cycle, none lost or duplicated.
4. Full-pipe simultaneous transfer: in_valid=1 and out_ready=1 continuously for 100 random pairs -> in_ready stays 1 and 100 results match the maths_addsub_core model in order.
5. Reset mid-flight: assert reset with 2 results in flight -> out_valid=0 immediately (asynchronously), count=0. After release, no stale result ever appears.
6. Counter wrap: preload via 65536 transfers -> count reads 0x0000 after the 65536th.
